// File: rtl/temp_i2c_read_engine.sv
// temp_i2c_read_engine: single-byte two-wire master read.
// START, address, ACK check, one data byte, NACK, STOP; open-drain pad enables.
module temp_i2c_read_engine #(
    parameter int CLK_DIV = 250
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       StartReading,
    input  logic [7:0] FirstByte,
    output logic [7:0] RecData,
    output logic       Done,
    output logic       Busy,
    output logic       AckError,
    output logic       SclOe,
    output logic       SdaOe,
    input  logic       SdaIn
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_READ,
        S_MNACK,
        S_STOP,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rec_q, rec_d;
    logic        ackerr_q, ackerr_d;
    logic        srd_q;
    logic        tick;
    logic        cell_end;
    logic        sample;

    assign tick     = (state_q != S_IDLE) && (cnt_q == 16'(CLK_DIV - 1));
    assign cell_end = tick && (qtr_q == 2'd3);
    assign sample   = tick && (qtr_q == 2'd2);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            qtr_q    <= '0;
            bit_q    <= '0;
            addr_q   <= '0;
            shift_q  <= '0;
            rec_q    <= '0;
            ackerr_q <= 1'b0;
            srd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            rec_q    <= rec_d;
            ackerr_q <= ackerr_d;
            srd_q    <= StartReading;
        end
    end

    always_comb begin
        state_d  = state_q;
        qtr_d    = tick ? qtr_q + 2'd1 : qtr_q;
        bit_d    = bit_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        rec_d    = rec_q;
        ackerr_d = ackerr_q;
        if (state_q == S_IDLE || state_q == S_DONE || tick)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 16'd1;

        unique case (state_q)
            S_IDLE: begin
                if (StartReading && !srd_q) begin
                    state_d  = S_START;
                    addr_d   = FirstByte;
                    ackerr_d = 1'b0;
                    qtr_d    = 2'd0;
                end
            end
            S_START: begin
                if (cell_end) begin
                    state_d = S_ADDR;
                    bit_d   = 3'd7;
                end
            end
            S_ADDR: begin
                if (cell_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = S_AACK;
                end
            end
            S_AACK: begin
                if (sample) ackerr_d = SdaIn;
                if (cell_end) begin
                    state_d = ackerr_q ? S_STOP : S_READ;
                    bit_d   = 3'd7;
                end
            end
            S_READ: begin
                if (sample) shift_d = {shift_q[6:0], SdaIn};
                if (cell_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = S_MNACK;
                end
            end
            S_MNACK: begin
                if (cell_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (cell_end) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!ackerr_q) rec_d = shift_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // SCL is low in the first half of every data cell
    always_comb begin
        SclOe = 1'b0;
        SdaOe = 1'b0;
        unique case (state_q)
            S_START: SdaOe = qtr_q[1];
            S_ADDR: begin
                SclOe = ~qtr_q[1];
                SdaOe = ~addr_q[bit_q];
            end
            S_AACK, S_READ, S_MNACK: SclOe = ~qtr_q[1];
            S_STOP: begin
                SclOe = (qtr_q == 2'd0);
                SdaOe = ~qtr_q[1];
            end
            default: begin
                SclOe = 1'b0;
                SdaOe = 1'b0;
            end
        endcase
    end

    assign Busy     = (state_q != S_IDLE);
    assign Done     = (state_q == S_DONE);
    assign RecData  = rec_q;
    assign AckError = ackerr_q;

endmodule

// File: tb/tb_temp_i2c_read_engine.sv
// tb_temp_i2c_read_engine: directed bench with a byte-returning slave
// model and a bus monitor on the open-drain lines.
module tb_temp_i2c_read_engine;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       srd;
    logic [7:0] fb;
    logic [7:0] rec;
    logic       done;
    logic       busy;
    logic       ackerr;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;

    temp_i2c_read_engine #(.CLK_DIV(DIV)) dut (
        .Clock        (clk),
        .Reset        (rst),
        .StartReading (srd),
        .FirstByte    (fb),
        .RecData      (rec),
        .Done         (done),
        .Busy         (busy),
        .AckError     (ackerr),
        .SclOe        (scl_oe),
        .SdaOe        (sda_oe),
        .SdaIn        (sda_in)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // slave configuration
    logic [7:0] s_data = 8'h00;
    bit         s_ack = 1'b1;
    logic       slv = 1'b1;
    int         k = 0;
    logic [7:0] cap = 8'h00;

    logic scl_l;
    logic sda_l;
    assign scl_l  = ~scl_oe;
    assign sda_l  = ~sda_oe & slv;
    assign sda_in = sda_l;

    // monitor state
    logic sclp = 1'b1;
    logic sdap = 1'b1;
    logic donep = 1'b0;
    int   n_start = 0;
    int   n_stop = 0;
    int   n_rise = 0;
    int   n_done = 0;
    int   n_wide = 0;
    int   bad_w = 0;
    int   t_rise = 0;
    int   t_fall = 0;

    always @(negedge clk) begin
        sclp  <= scl_l;
        sdap  <= sda_l;
        donep <= done;
        if (rst) begin
            k   <= 0;
            slv <= 1'b1;
        end else begin
            if (done && !donep) n_done <= n_done + 1;
            if (done && donep) n_wide <= n_wide + 1;
            if (scl_l && sclp && sda_l != sdap) begin
                if (!sda_l) n_start <= n_start + 1;
                else n_stop <= n_stop + 1;
            end
            if (scl_l && sclp && !sda_l && sdap) begin
                k <= 0;
            end else if (!scl_l && sclp) begin
                k <= k + 1;
                if (k + 1 == 9)
                    slv <= ~s_ack;
                else if (k + 1 >= 10 && k + 1 <= 17 && s_ack)
                    slv <= s_data[17-(k+1)];
                else
                    slv <= 1'b1;
            end
            if (scl_l && !sclp) begin
                t_rise <= cyc;
                n_rise <= n_rise + 1;
                if (k >= 1 && k <= 8) cap[8-k] <= sda_l;
                if (cyc - t_fall != 2 * DIV && cyc - t_fall != DIV)
                    bad_w <= bad_w + 1;
            end
            if (!scl_l && sclp) begin
                t_fall <= cyc;
                if (cyc - t_rise < 4 * DIV && cyc - t_rise != 2 * DIV)
                    bad_w <= bad_w + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [7:0] f, input logic [7:0] d,
                           input bit a, input bit hold, input bit glitch,
                           output int lat);
        int c0;
        int t;
        @(negedge clk);
        fb     = f;
        s_data = d;
        s_ack  = a;
        srd    = 1'b1;
        c0     = cyc;
        @(negedge clk);
        if (!hold) srd = 1'b0;
        check("busy_on", busy, 1);
        t = 0;
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
            if (glitch && t == 50) srd = 1'b0;
            if (glitch && t == 52) srd = 1'b1;
        end
        check("done_seen", done, 1);
        lat = cyc - (c0 + 1);
        @(negedge clk);
        check("busy_off", busy, 0);
        check("done_1cyc", done, 0);
    endtask

    int lat;
    int s0, p0, r0, d0, c1;

    initial begin
        rst = 1'b1;
        srd = 1'b0;
        fb  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rec", rec, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ackerr", ackerr, 0);
        check("rst_scl", scl_oe, 0);
        check("rst_sda", sda_oe, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // normal read
        s0 = n_start; p0 = n_stop; r0 = n_rise;
        run_txn(8'h91, 8'h1A, 1'b1, 1'b0, 1'b0, lat);
        check("t1_lat", (lat >= 320 && lat <= 322), 1);
        check("t1_addr", cap, 8'h91);
        check("t1_rec", rec, 8'h1A);
        check("t1_ackerr", ackerr, 0);
        check("t1_starts", n_start - s0, 1);
        check("t1_stops", n_stop - p0, 1);
        check("t1_sclrise", n_rise - r0, 19);

        // address NACK
        s0 = n_start; p0 = n_stop; r0 = n_rise;
        run_txn(8'h91, 8'h77, 1'b0, 1'b0, 1'b0, lat);
        check("t2_lat", (lat >= 176 && lat <= 178), 1);
        check("t2_ackerr", ackerr, 1);
        check("t2_rec", rec, 8'h1A);
        check("t2_starts", n_start - s0, 1);
        check("t2_stops", n_stop - p0, 1);
        check("t2_sclrise", n_rise - r0, 10);
        r0 = n_rise;
        repeat (100) @(negedge clk);
        check("t2_noscl", n_rise - r0, 0);

        // held StartReading, then re-edge with a glitch while busy
        d0 = n_done;
        run_txn(8'h91, 8'h3C, 1'b1, 1'b1, 1'b0, lat);
        check("t3_rec1", rec, 8'h3C);
        check("t3_ackclr", ackerr, 0);
        repeat (400) @(negedge clk);
        check("t3_once", n_done - d0, 1);
        srd = 1'b0;
        d0 = n_done;
        run_txn(8'h91, 8'h5A, 1'b1, 1'b1, 1'b1, lat);
        check("t3_rec2", rec, 8'h5A);
        repeat (400) @(negedge clk);
        check("t3_noglitch", n_done - d0, 1);
        srd = 1'b0;
        repeat (2) @(negedge clk);

        // reset during quarter 30
        @(negedge clk);
        fb = 8'h91; s_data = 8'hC3; s_ack = 1'b1; srd = 1'b1;
        c1 = cyc;
        @(negedge clk);
        srd = 1'b0;
        repeat (30 * DIV + 1) @(negedge clk);
        check("t4_q30", cyc - (c1 + 1), 30 * DIV + 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_scl", scl_oe, 0);
        check("t4_sda", sda_oe, 0);
        check("t4_busy", busy, 0);
        d0 = n_done;
        repeat (400) @(negedge clk);
        check("t4_nodone", n_done - d0, 0);
        run_txn(8'h91, 8'hC3, 1'b1, 1'b0, 1'b0, lat);
        check("t4_rec", rec, 8'hC3);
        check("t4_lat", (lat >= 320 && lat <= 322), 1);

        // back-to-back reads
        d0 = n_done;
        run_txn(8'h91, 8'h55, 1'b1, 1'b0, 1'b0, lat);
        check("t6_rec1", rec, 8'h55);
        run_txn(8'h93, 8'hAA, 1'b1, 1'b0, 1'b0, lat);
        check("t6_addr2", cap, 8'h93);
        check("t6_rec2", rec, 8'hAA);
        check("t6_dones", n_done - d0, 2);

        check("scl_widths", bad_w, 0);
        check("done_wide", n_wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
